// File: rtl/memory_bus_bridge_pkg.sv
// Shared configuration for the core-to-Wishbone memory bridge.
// Latency: none (constants and helper functions only).
// Backpressure: not applicable.
package memory_bus_bridge_pkg;

    // RV64I data path: 64-bit bus, 8 byte lanes.
    localparam int MBB_DATA_WIDTH     = 64;
    localparam int MBB_ADDR_WIDTH     = 64;
    localparam int MBB_TIMEOUT_CYCLES = 255;

    // Width of the byte-offset field within a bus word.
    function automatic int lane_off_w(input int byte_num);
        return (byte_num > 1) ? $clog2(byte_num) : 1;
    endfunction

endpackage

// File: rtl/byte_lane_aligner.sv
// Moves LSB-aligned core data/masks onto Wishbone byte lanes and back.
// Latency: purely combinational.
// Backpressure: none; flags masks that spill past the end of the bus word.
//   i_addr/i_byte_en/i_wr_data : request from core (LSB-aligned)
//   i_rd_word/i_rd_offset      : raw bus read word and the offset of its access
//   o_sel/o_dat/o_adr          : lane-shifted select, store data, word address
//   o_offset/o_misaligned      : byte offset within word, boundary-crossing flag
//   o_rd_data                  : read word shifted back down to LSB alignment
import memory_bus_bridge_pkg::*;

module byte_lane_aligner #(
    parameter int DATA_WIDTH = MBB_DATA_WIDTH,
    parameter int ADDR_WIDTH = MBB_ADDR_WIDTH,
    parameter int BYTE_NUM   = DATA_WIDTH / 8,
    parameter int OFF_W      = lane_off_w(DATA_WIDTH / 8)
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [BYTE_NUM-1:0]   i_byte_en,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [DATA_WIDTH-1:0] i_rd_word,
    input  logic [OFF_W-1:0]      i_rd_offset,
    output logic [BYTE_NUM-1:0]   o_sel,
    output logic [DATA_WIDTH-1:0] o_dat,
    output logic [ADDR_WIDTH-1:0] o_adr,
    output logic [OFF_W-1:0]      o_offset,
    output logic                  o_misaligned,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [OFF_W-1:0]      w_off;
    logic [2*BYTE_NUM-1:0] w_wide_sel;

    assign w_off = i_addr[OFF_W-1:0];

    // Shift into a double-width mask: any bit landing in the upper half
    // means the access straddles two bus words.
    assign w_wide_sel   = {{BYTE_NUM{1'b0}}, i_byte_en} << w_off;
    assign o_sel        = w_wide_sel[BYTE_NUM-1:0];
    assign o_misaligned = |w_wide_sel[2*BYTE_NUM-1:BYTE_NUM];

    assign o_dat     = i_wr_data << {w_off, 3'b000};
    assign o_adr     = {i_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
    assign o_offset  = w_off;
    assign o_rd_data = i_rd_word >> {i_rd_offset, 3'b000};

endmodule

// File: rtl/memory_bus_bridge.sv
// Bridges single-beat core loads/stores onto a classic Wishbone master port.
// Latency: acceptance + 1 + slave wait + 1 (one BUS cycle minimum, one DONE cycle).
// Backpressure: mem_busy high while the bus cycle is open; requests only taken in IDLE.
//   i_clk/i_reset   : clock, synchronous active-high reset
//   i_flush         : abandon the in-flight access (bus cycle drained, no completion)
//   i_mem_*         : core request; o_mem_busy/o_mem_rd_data/o_mem_fault: core response
//   o_wb_*/i_wb_*   : Wishbone master signals
import memory_bus_bridge_pkg::*;

module memory_bus_bridge #(
    parameter int DATA_WIDTH     = MBB_DATA_WIDTH,
    parameter int ADDR_WIDTH     = MBB_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = MBB_TIMEOUT_CYCLES,
    parameter int BYTE_NUM       = DATA_WIDTH / 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_flush,
    input  logic                  i_mem_rd_en,
    input  logic                  i_mem_wr_en,
    input  logic [BYTE_NUM-1:0]   i_mem_byte_en,
    input  logic [ADDR_WIDTH-1:0] i_mem_addr,
    input  logic [DATA_WIDTH-1:0] i_mem_wr_data,
    output logic                  o_mem_busy,
    output logic [DATA_WIDTH-1:0] o_mem_rd_data,
    output logic                  o_mem_fault,
    output logic                  o_wb_cyc,
    output logic                  o_wb_stb,
    output logic                  o_wb_we,
    output logic [BYTE_NUM-1:0]   o_wb_sel,
    output logic [ADDR_WIDTH-1:0] o_wb_adr,
    output logic [DATA_WIDTH-1:0] o_wb_dat_o,
    input  logic [DATA_WIDTH-1:0] i_wb_dat_i,
    input  logic                  i_wb_ack,
    input  logic                  i_wb_err
);

    localparam int OFF_W = lane_off_w(BYTE_NUM);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUS   = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_we;
    logic [BYTE_NUM-1:0]   r_sel;
    logic [ADDR_WIDTH-1:0] r_adr;
    logic [DATA_WIDTH-1:0] r_dat_o;
    logic [OFF_W-1:0]      r_off;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_mem_fault;

    logic [BYTE_NUM-1:0]   w_sel;
    logic [DATA_WIDTH-1:0] w_dat_o;
    logic [ADDR_WIDTH-1:0] w_adr;
    logic [OFF_W-1:0]      w_off;
    logic                  w_misaligned;
    logic [DATA_WIDTH-1:0] w_rd_shifted;
    logic                  w_timeout;
    logic                  w_bus_end;

    byte_lane_aligner #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .BYTE_NUM   (BYTE_NUM),
        .OFF_W      (OFF_W)
    ) u_aligner (
        .i_addr       (i_mem_addr),
        .i_byte_en    (i_mem_byte_en),
        .i_wr_data    (i_mem_wr_data),
        .i_rd_word    (i_wb_dat_i),
        .i_rd_offset  (r_off),
        .o_sel        (w_sel),
        .o_dat        (w_dat_o),
        .o_adr        (w_adr),
        .o_offset     (w_off),
        .o_misaligned (w_misaligned),
        .o_rd_data    (w_rd_shifted)
    );

    // Counter starts at 0 in the first BUS cycle, so a silent slave gets
    // TIMEOUT_CYCLES+1 bus cycles before the access is abandoned.
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES));
    assign w_bus_end = i_wb_ack | i_wb_err | w_timeout;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_sel       <= '0;
            r_adr       <= '0;
            r_dat_o     <= '0;
            r_off       <= '0;
            r_rd_data   <= '0;
            r_mem_fault <= 1'b0;
        end else begin
            r_mem_fault <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_mem_rd_en && i_mem_wr_en) begin
                        // Ambiguous direction: refuse and report.
                        r_mem_fault <= 1'b1;
                    end else if (i_mem_rd_en || i_mem_wr_en) begin
                        r_we    <= i_mem_wr_en;
                        r_sel   <= w_sel;
                        r_adr   <= w_adr;
                        r_dat_o <= w_dat_o;
                        r_off   <= w_off;
                        r_cnt   <= '0;
                        if (w_misaligned) begin
                            r_state     <= S_DONE;
                            r_mem_fault <= 1'b1;
                            r_rd_data   <= '0;
                        end else begin
                            r_state <= S_BUS;
                        end
                    end
                end
                S_BUS: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (i_flush) begin
                        // If the slave finishes in the flush cycle there is
                        // nothing left to drain.
                        r_state <= w_bus_end ? S_IDLE : S_DRAIN;
                    end else if (i_wb_err || (w_timeout && !i_wb_ack)) begin
                        r_state     <= S_DONE;
                        r_mem_fault <= 1'b1;
                        r_rd_data   <= '0;
                    end else if (i_wb_ack) begin
                        r_state   <= S_DONE;
                        r_rd_data <= w_rd_shifted;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                S_DRAIN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_bus_end) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_mem_busy    = (r_state == S_BUS);
    assign o_mem_rd_data = r_rd_data;
    assign o_mem_fault   = r_mem_fault;
    assign o_wb_cyc      = (r_state == S_BUS) || (r_state == S_DRAIN);
    assign o_wb_stb      = o_wb_cyc;
    assign o_wb_we       = o_wb_cyc & r_we;
    assign o_wb_sel      = r_sel;
    assign o_wb_adr      = r_adr;
    assign o_wb_dat_o    = r_dat_o;

endmodule

// File: tb/tb_memory_bus_bridge.sv
module tb_memory_bus_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        rd_en;
    logic        wr_en;
    logic [7:0]  byte_en;
    logic [63:0] addr;
    logic [63:0] wr_data;
    logic        busy;
    logic [63:0] rd_data;
    logic        fault;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [7:0]  sel;
    logic [63:0] adr;
    logic [63:0] dat_o;
    logic [63:0] dat_i;
    logic        ack;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_rd;
    int busy_cycles;

    memory_bus_bridge dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_flush       (flush),
        .i_mem_rd_en   (rd_en),
        .i_mem_wr_en   (wr_en),
        .i_mem_byte_en (byte_en),
        .i_mem_addr    (addr),
        .i_mem_wr_data (wr_data),
        .o_mem_busy    (busy),
        .o_mem_rd_data (rd_data),
        .o_mem_fault   (fault),
        .o_wb_cyc      (cyc),
        .o_wb_stb      (stb),
        .o_wb_we       (we),
        .o_wb_sel      (sel),
        .o_wb_adr      (adr),
        .o_wb_dat_o    (dat_o),
        .i_wb_dat_i    (dat_i),
        .i_wb_ack      (ack),
        .i_wb_err      (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called in the first BUS cycle. Holds the slave silent for wait_cycles,
    // then drives ack/err for one cycle; returns with the DUT one cycle later.
    task automatic slave_respond(input int wait_cycles, input logic a, input logic e,
                                 input logic [63:0] d, output int bc);
        bc = 0;
        for (int i = 0; i < wait_cycles; i++) begin
            if (busy) bc++;
            tick();
        end
        if (busy) bc++;
        ack = a; err = e; dat_i = d;
        tick();
        ack = 1'b0; err = 1'b0;
    endtask

    task automatic request(input logic r, input logic w, input logic [63:0] a,
                           input logic [7:0] be, input logic [63:0] wd);
        rd_en = r; wr_en = w; addr = a; byte_en = be; wr_data = wd;
    endtask

    task automatic drop();
        rd_en = 1'b0; wr_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
        byte_en = '0; addr = '0; wr_data = '0; dat_i = '0; ack = 1'b0; err = 1'b0;
        tick(); tick();

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_fault", fault, 0);
        check("rst_cyc", cyc, 0);
        check("rst_stb", stb, 0);
        check("rst_we", we, 0);
        check("rst_sel", sel, 0);
        check("rst_adr", adr, 0);
        check("rst_dat_o", dat_o, 0);
        check("rst_rd_data", rd_data, 0);
        reset = 1'b0;
        tick();

        // Offset read, slave acks after 3 wait cycles
        request(1, 0, 64'h1004, 8'h0F, 0);
        exp_q.push_back(64'hAABBCCDD_11223344 >> 32);
        tick();
        check("rd_busy", busy, 1);
        check("rd_cyc", cyc, 1);
        check("rd_we", we, 0);
        check("rd_sel", sel, 8'hF0);
        check("rd_adr", adr, 64'h1000);
        drop();
        slave_respond(3, 1, 0, 64'hAABBCCDD_11223344, busy_cycles);
        check("rd_busy_cycles", busy_cycles, 4);
        check("rd_done_busy", busy, 0);
        check("rd_done_cyc", cyc, 0);
        check("rd_done_fault", fault, 0);
        exp_rd = exp_q.pop_front();
        check("rd_data", rd_data, exp_rd);
        tick();

        // Single-byte write at offset 3
        request(0, 1, 64'h2003, 8'h01, 64'h5A);
        tick();
        check("wr_sel", sel, 8'h08);
        check("wr_dat_o", dat_o, 64'h5A000000);
        check("wr_we", we, 1);
        check("wr_stb", stb, 1);
        check("wr_adr", adr, 64'h2000);
        drop();
        slave_respond(0, 1, 0, 64'h0, busy_cycles);
        check("wr_busy_cycles", busy_cycles, 1);
        check("wr_fault", fault, 0);
        tick();

        // Misaligned: mask crosses word boundary, no bus cycle
        request(1, 0, 64'h0006, 8'h0F, 0);
        tick();
        check("mis_cyc", cyc, 0);
        check("mis_busy", busy, 0);
        check("mis_fault", fault, 1);
        drop();
        tick();
        check("mis_fault_pulse", fault, 0);
        check("mis_busy_idle", busy, 0);
        check("mis_cyc_idle", cyc, 0);
        tick();

        // Timeout with silent slave; prime rd_data first so zeroing is visible
        request(1, 0, 64'h8, 8'hFF, 0);
        exp_q.push_back(64'h01234567_89ABCDEF);
        tick(); drop();
        slave_respond(0, 1, 0, 64'h01234567_89ABCDEF, busy_cycles);
        exp_rd = exp_q.pop_front();
        check("prime_rd_data", rd_data, exp_rd);
        tick();
        request(1, 0, 64'h3000, 8'hFF, 0);
        exp_q.push_back(64'h0);
        tick(); drop();
        busy_cycles = 0;
        for (int i = 0; i < 1000 && busy; i++) begin
            busy_cycles++;
            tick();
        end
        check("to_busy_cycles", busy_cycles, 256);
        check("to_fault", fault, 1);
        check("to_cyc", cyc, 0);
        exp_rd = exp_q.pop_front();
        check("to_rd_data", rd_data, exp_rd);
        tick();
        check("to_fault_pulse", fault, 0);

        // Prime again, then wb_err (with ack) on the 2nd BUS cycle
        request(1, 0, 64'h18, 8'hFF, 0);
        exp_q.push_back(64'hFEEDFACE_0BADF00D);
        tick(); drop();
        slave_respond(0, 1, 0, 64'hFEEDFACE_0BADF00D, busy_cycles);
        exp_rd = exp_q.pop_front();
        check("prime2_rd_data", rd_data, exp_rd);
        tick();
        request(1, 0, 64'h10, 8'hFF, 0);
        exp_q.push_back(64'h0);
        tick(); drop();
        slave_respond(1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, busy_cycles);
        check("err_busy_cycles", busy_cycles, 2);
        check("err_fault", fault, 1);
        exp_rd = exp_q.pop_front();
        check("err_rd_data", rd_data, exp_rd);
        tick();
        check("err_idle_busy", busy, 0);
        check("err_fault_pulse", fault, 0);

        // Known rd_data before flush
        request(1, 0, 64'h20, 8'h03, 0);
        exp_q.push_back(64'h0000_0000_0000_BEEF);
        tick(); drop();
        slave_respond(0, 1, 0, 64'h0000_0000_0000_BEEF, busy_cycles);
        exp_rd = exp_q.pop_front();
        check("pre_flush_rd", rd_data, exp_rd);
        tick();

        // Flush in 2nd BUS cycle with the next request held
        request(1, 0, 64'h40, 8'hFF, 0);
        exp_q.push_back(64'h0000_0000_0000_BEEF);
        tick();
        tick();
        check("fl_bus2_busy", busy, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_drain_busy", busy, 0);
        check("fl_drain_cyc", cyc, 1);
        check("fl_drain_fault", fault, 0);
        tick(); tick();
        check("fl_drain_hold_cyc", cyc, 1);
        check("fl_drain_hold_busy", busy, 0);
        ack = 1'b1; dat_i = 64'hDEAD_DEAD_DEAD_DEAD;
        tick();
        ack = 1'b0;
        check("fl_idle_cyc", cyc, 0);
        check("fl_idle_fault", fault, 0);
        check("fl_idle_busy", busy, 0);
        exp_rd = exp_q.pop_front();
        check("fl_rd_unchanged", rd_data, exp_rd);
        tick();
        check("fl_new_accept", busy, 1);
        check("fl_new_adr", adr, 64'h40);
        drop();
        exp_q.push_back(64'h11112222_33334444);
        slave_respond(0, 1, 0, 64'h11112222_33334444, busy_cycles);
        exp_rd = exp_q.pop_front();
        check("fl_new_rd", rd_data, exp_rd);
        tick();

        // Both directions requested: refused with a fault pulse
        request(1, 1, 64'h50, 8'hFF, 0);
        tick();
        check("both_fault", fault, 1);
        check("both_busy", busy, 0);
        check("both_cyc", cyc, 0);
        drop();
        tick();
        check("both_fault_pulse", fault, 0);
        check("both_still_idle", busy, 0);

        // Flush in IDLE has no effect on acceptance
        request(1, 0, 64'h104, 8'h03, 0);
        flush = 1'b1;
        exp_q.push_back(64'hCAFEF00D_DEADBEEF >> 32);
        tick();
        flush = 1'b0;
        drop();
        check("idle_flush_busy", busy, 1);
        check("idle_flush_sel", sel, 8'h30);
        check("idle_flush_adr", adr, 64'h100);
        slave_respond(0, 1, 0, 64'hCAFEF00D_DEADBEEF, busy_cycles);
        exp_rd = exp_q.pop_front();
        check("idle_flush_rd", rd_data, exp_rd);
        tick();

        // Reset in the middle of a bus cycle
        request(1, 0, 64'h200, 8'hFF, 0);
        tick(); drop();
        tick();
        check("mid_rst_bus", cyc, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_cyc", cyc, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_fault", fault, 0);
        check("mid_rst_rd", rd_data, 0);
        tick();
        check("mid_rst_no_fault", fault, 0);
        check("mid_rst_idle", busy, 0);

        check("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
